// File: rtl/i2c_host_master.sv
// i2c_host_master: byte-level I2C initiator driving open-drain SCL/SDA enables from a start/byte/stop command stream.
module i2c_host_master #(
  parameter int CLOCKFREQ = 50000000,
  parameter int I2CFREQ   = 400000
) (
  input  logic       clock_sig,
  input  logic       reset_sig,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_start,
  input  logic       cmd_stop,
  input  logic       cmd_read,
  input  logic       cmd_nack,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_nack,
  output logic       busy,
  output logic       bus_held,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe
);
  localparam int DIV_RAW = CLOCKFREQ / (I2CFREQ * 4);
  localparam int DIV = DIV_RAW < 1 ? 1 : DIV_RAW;
  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  typedef enum logic [2:0] {IDLE, START, BYTE, STOP, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] ph_q, ph_d;
  logic [3:0] bit_q, bit_d;
  logic [7:0] data_q, data_d, sh_q, sh_d, rsp_data_q, rsp_data_d;
  logic stop_q, stop_d, read_q, read_d, nack_q, nack_d, ack_q, ack_d, held_q, held_d;
  logic rsp_valid_q, rsp_valid_d, rsp_nack_q, rsp_nack_d;
  logic stretch, hold, tick, last, accept, sample, quiet, bit_sda;
  always_ff @(posedge clock_sig) begin
    if (reset_sig) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ph_q        <= '0;
      bit_q       <= '0;
      data_q      <= '0;
      sh_q        <= '0;
      stop_q      <= 1'b0;
      read_q      <= 1'b0;
      nack_q      <= 1'b0;
      ack_q       <= 1'b0;
      held_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_nack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ph_q        <= ph_d;
      bit_q       <= bit_d;
      data_q      <= data_d;
      sh_q        <= sh_d;
      stop_q      <= stop_d;
      read_q      <= read_d;
      nack_q      <= nack_d;
      ack_q       <= ack_d;
      held_q      <= held_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_nack_q  <= rsp_nack_d;
    end
  end
  always_comb begin
    // phases where SCL is released wait for the target to let it rise
    stretch = (state_q == BYTE && ph_q == 2'd2) || ((state_q == START || state_q == STOP) && ph_q == 2'd1);
    hold    = stretch && !scl_in;
    tick    = !hold && cnt_q == LAST;
    last    = tick && ph_q == 2'd3;
    quiet   = state_q == IDLE || state_q == DONE;
    accept  = cmd_valid && state_q == IDLE;
    sample  = state_q == BYTE && ph_q == 2'd2 && tick;
    cnt_d   = (quiet || tick) ? '0 : hold ? cnt_q : cnt_q + CW'(1);
    ph_d    = quiet ? 2'd0 : ph_q + 2'(tick);
    bit_d   = state_q == BYTE ? bit_q + 4'(last) : 4'd0;
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = accept ? (cmd_start ? START : BYTE) : IDLE;
      START:   state_d = last ? BYTE : START;
      BYTE:    state_d = (last && bit_q == 4'd8) ? (stop_q ? STOP : DONE) : BYTE;
      STOP:    state_d = last ? DONE : STOP;
      default: state_d = IDLE;
    endcase
    data_d      = accept ? cmd_data : data_q;
    stop_d      = accept ? cmd_stop : stop_q;
    read_d      = accept ? cmd_read : read_q;
    nack_d      = accept ? cmd_nack : nack_q;
    sh_d        = (sample && !bit_q[3]) ? {sh_q[6:0], sda_in} : sh_q;
    ack_d       = (sample && bit_q[3]) ? sda_in : ack_q;
    held_d      = (state_q == START && last) ? 1'b1 : (state_q == STOP && last) ? 1'b0 : held_q;
    rsp_valid_d = state_q == DONE;
    rsp_data_d  = state_q == DONE ? sh_q : rsp_data_q;
    rsp_nack_d  = state_q == DONE ? ack_q : rsp_nack_q;
  end
  always_comb begin
    bit_sda   = bit_q[3] ? (read_q && !nack_q) : (!read_q && !data_q[~bit_q[2:0]]);
    scl_oe    = state_q == START ? (ph_q == 2'd0 || ph_q == 2'd3) :
                state_q == BYTE  ? !ph_q[1] :
                state_q == STOP  ? ph_q == 2'd0 : held_q;
    sda_oe    = state_q == START ? ph_q[1] :
                state_q == BYTE  ? bit_sda :
                state_q == STOP  ? !ph_q[1] : 1'b0;
    cmd_ready = state_q == IDLE;
    busy      = state_q != IDLE;
    rsp_valid = rsp_valid_q;
    rsp_data  = rsp_data_q;
    rsp_nack  = rsp_nack_q;
    bus_held  = held_q;
  end
endmodule

// File: tb/tb_i2c_host_master.sv
// tb_i2c_host_master: directed checks of i2c_host_master against an open-drain bus with a simple target model.
module tb_i2c_host_master;
  logic clk = 1'b0;
  logic reset_sig, cmd_valid, cmd_ready, cmd_start, cmd_stop, cmd_read, cmd_nack;
  logic [7:0] cmd_data, rsp_data;
  logic rsp_valid, rsp_nack, busy, bus_held, scl_in, sda_in, scl_oe, sda_oe;
  int n_vec = 0, n_err = 0, cyc = 0;
  // target model state
  logic tgt_clr = 1'b0, rd_mode = 1'b0, ack_en = 1'b0, str_en = 1'b0;
  logic [7:0] tx = '0, rx = '0;
  logic scl_p = 1'b1, sda_p = 1'b1, dr = 1'b0, fl = 1'b0, hold_scl;
  int tcnt = 0, str_n = 0, n_start = 0, n_stop = 0;
  i2c_host_master #(.CLOCKFREQ(1600), .I2CFREQ(100)) dut (
    .clock_sig(clk), .reset_sig(reset_sig), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_read(cmd_read), .cmd_nack(cmd_nack),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nack(rsp_nack),
    .busy(busy), .bus_held(bus_held), .scl_in(scl_in), .sda_in(sda_in),
    .scl_oe(scl_oe), .sda_oe(sda_oe));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign hold_scl = str_en && tcnt == 3 && fl && str_n < 50;
  assign scl_in = !(scl_oe || hold_scl);
  assign sda_in = !(sda_oe || dr);
  always @(posedge clk) begin
    scl_p <= scl_in;
    sda_p <= sda_in;
    if (hold_scl && !scl_oe) str_n <= str_n + 1;
    if (tgt_clr) begin
      tcnt <= 0; dr <= 1'b0; fl <= 1'b0; str_n <= 0;
    end else if (scl_p && scl_in && sda_p && !sda_in) begin
      tcnt <= 0; n_start <= n_start + 1;
    end else if (scl_p && scl_in && !sda_p && sda_in) begin
      n_stop <= n_stop + 1;
    end else if (!scl_p && scl_in) begin
      if (tcnt < 8) rx <= {rx[6:0], sda_in};
      tcnt <= tcnt + 1; fl <= 1'b0;
    end else if (scl_p && !scl_in) begin
      fl <= 1'b1;
      dr <= (rd_mode && tcnt < 8) ? !tx[7-tcnt] : (!rd_mode && tcnt == 8 && ack_en);
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clr_tgt();
    @(negedge clk) tgt_clr = 1'b1;
    @(negedge clk) tgt_clr = 1'b0;
  endtask
  task automatic wait_rsp(input int t0, output int lat);
    lat = -1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin lat = cyc - t0; break; end
    end
  endtask
  task automatic run_cmd(input logic s, p, r, n, input logic [7:0] d, output int lat);
    int t0;
    @(negedge clk);
    cmd_start = s; cmd_stop = p; cmd_read = r; cmd_nack = n; cmd_data = d; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    t0 = cyc;
    wait_rsp(t0, lat);
  endtask
  initial begin
    int lat, s0, p0, t0;
    reset_sig = 1'b1; cmd_valid = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0;
    cmd_read = 1'b0; cmd_nack = 1'b0; cmd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl_oe", scl_oe, 0); chk("rst_sda_oe", sda_oe, 0); chk("rst_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0); chk("rst_rsp_data", rsp_data, 0); chk("rst_rsp_nack", rsp_nack, 0);
    chk("rst_busy", busy, 0); chk("rst_held", bus_held, 0);
    @(negedge clk) reset_sig = 1'b0;
    clr_tgt();
    // 1: write 0xA0 with start and stop, target acks
    ack_en = 1'b1; rd_mode = 1'b0; s0 = n_start; p0 = n_stop;
    run_cmd(1, 1, 0, 0, 8'hA0, lat);
    chk("t1_lat", lat, 177); chk("t1_data", rsp_data, 8'hA0); chk("t1_nack", rsp_nack, 0);
    chk("t1_held", bus_held, 0); chk("t1_rx", rx, 8'hA0);
    chk("t1_starts", n_start - s0, 1); chk("t1_stops", n_stop - p0, 1);
    // 2: absent target
    clr_tgt(); ack_en = 1'b0;
    run_cmd(1, 1, 0, 0, 8'h55, lat);
    chk("t2_nack", rsp_nack, 1); chk("t2_data", rsp_data, 8'h55); chk("t2_lat", lat, 177);
    // 3: read 0x3C without start, NACK last byte, then stop
    clr_tgt(); rd_mode = 1'b1; tx = 8'h3C; p0 = n_stop;
    run_cmd(0, 1, 1, 1, 8'h00, lat);
    chk("t3_data", rsp_data, 8'h3C); chk("t3_nack", rsp_nack, 1);
    chk("t3_lat", lat, 161); chk("t3_stops", n_stop - p0, 1);
    // 4: write without stop, then read behind a repeated start
    clr_tgt(); rd_mode = 1'b0; ack_en = 1'b1; s0 = n_start;
    run_cmd(1, 0, 0, 0, 8'hA1, lat);
    chk("t4a_lat", lat, 161); chk("t4a_nack", rsp_nack, 0);
    @(negedge clk);
    chk("t4_held_between", bus_held, 1); chk("t4_scl_low", scl_in, 0);
    rd_mode = 1'b1; tx = 8'h96;
    run_cmd(1, 1, 1, 1, 8'h00, lat);
    chk("t4b_lat", lat, 177); chk("t4b_data", rsp_data, 8'h96);
    chk("t4_starts", n_start - s0, 2); chk("t4b_held", bus_held, 0);
    // 5: target stretches SCL 50 cycles in bit 3
    clr_tgt(); rd_mode = 1'b0; ack_en = 1'b1; str_en = 1'b1;
    run_cmd(1, 1, 0, 0, 8'h5A, lat);
    chk("t5_lat", lat, 227); chk("t5_data", rsp_data, 8'h5A);
    chk("t5_nack", rsp_nack, 0); chk("t5_stretch", str_n, 50);
    str_en = 1'b0;
    // 6: reset mid-byte, then back-to-back valid gated by ready
    clr_tgt(); ack_en = 1'b0;
    @(negedge clk);
    cmd_start = 1'b0; cmd_stop = 1'b0; cmd_read = 1'b0; cmd_data = 8'h81; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1 chk("t6_mid_scl", scl_oe, 1);
    @(negedge clk) reset_sig = 1'b1;
    @(posedge clk); #1;
    chk("t6_scl_oe", scl_oe, 0); chk("t6_sda_oe", sda_oe, 0);
    chk("t6_ready", cmd_ready, 1); chk("t6_busy", busy, 0);
    @(negedge clk) reset_sig = 1'b0;
    clr_tgt();
    @(negedge clk) cmd_valid = 1'b1;
    @(posedge clk); #1 t0 = cyc;
    chk("t6_ready_drop", cmd_ready, 0); chk("t6_busy_up", busy, 1);
    wait_rsp(t0, lat);
    chk("t6_lat1", lat, 145);
    t0 = cyc;
    wait_rsp(t0, lat);
    cmd_valid = 1'b0;
    chk("t6_lat2", lat, 146); chk("t6_data", rsp_data, 8'h81);
    @(posedge clk); #1 chk("t6_idle", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
